window3x3_gen: RTL and testbench
================================

WINDOW3X3_GEN -- requirements
Module: window3x3_gen

Interface
REQ-001 Parameter IMG_W, default 640, pixels per line (range 3..1023).
REQ-002 Parameter IMG_H, default 480, lines per frame (range 3..1023).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-low reset.
REQ-005 pix_in  input  12  RGB444 pixel: [11:8] R, [7:4] G, [3:0] B.
REQ-006 pix_valid  input  1  pix_in present this cycle.
REQ-007 sof  input  1  qualifies pix_in as pixel (0,0) of a frame.
REQ-008 in_ready  output  1  block can accept a pixel this cycle.
REQ-009 color_data  output  108  3x3 window: [107:96] center, [95:84] left, [83:72] right, [71:60] up, [59:48] down, [47:36] up-left, [35:24] up-right, [23:12] down-left, [11:0] down-right.
REQ-010 window_valid  output  1  color_data valid, one-cycle pulse per window.
REQ-011 win_x, win_y  output  10 each  center coordinates of current window.
REQ-012 eof_out  output  1  high with window_valid on window (IMG_W-1, IMG_H-1).

Function
REQ-013 A pixel SHALL be accepted iff pix_valid && in_ready; raster order, x fastest.
REQ-014 States SHALL be IDLE, FILL, RUN, EOL, DRAIN.
REQ-015 IDLE: in_ready=1; non-sof pixels dropped; accepted sof pixel -> FILL at (0,0).
REQ-016 FILL: row 0 stored; no windows; after (IMG_W-1,0) -> RUN.
REQ-017 RUN: accepting (x,y), x>=1, y>=1, SHALL emit the window centered (x-1,y-1) in the next cycle.
REQ-018 Accepting (IMG_W-1,y), y>=1 SHALL enter EOL: one cycle, in_ready=0, emits center (IMG_W-1,y-1) next cycle; then RUN, or DRAIN if y=IMG_H-1.
REQ-019 DRAIN: in_ready=0 for IMG_W cycles; emits row IMG_H-1 centers x=0..IMG_W-1 on consecutive cycles; then IDLE.
REQ-020 Edges SHALL use replication: out-of-image neighbours take the nearest in-image pixel (clamp x and y independently).
REQ-021 Exactly IMG_W*IMG_H windows per frame, in raster order of center.
REQ-022 Accepted sof in FILL/RUN SHALL abort the frame: no window for the abort cycle, pixel becomes (0,0), state FILL.
REQ-023 sof while in_ready=0 SHALL be ignored (pixel not accepted).
REQ-024 Gaps in pix_valid SHALL stall without emitting windows or altering state.
REQ-025 color_data, win_x, win_y, eof_out SHALL hold their last value when window_valid=0.

Reset
REQ-026 On reset low: state IDLE, in_ready=1, color_data=0, window_valid=0, win_x=win_y=0, eof_out=0, counters 0.
REQ-027 Line-buffer storage is not reset; reset mid-frame discards the frame.
REQ-028 Reset deassertion SHALL be synchronised before use.

Structure
REQ-029 Shared package SHALL hold the nine field offsets of color_data, pixel width (12), and the state enum.
REQ-030 One sub-module line_buffer (IMG_W x 12, write-and-read same address per cycle, read-before-write) SHALL be instantiated twice for rows y-1, y-2.
REQ-031 Column shift registers (3x3) and FSM live in window3x3_gen; all outputs registered.

Verification (IMG_W=4, IMG_H=3, pixel (x,y)=12'h0YX unless noted)
REQ-032 Full frame, pix_valid always high -> 12 windows; first: center 000, left 000, right 001, up 000, down 010, UL 000, UR 001, DL 010, DR 011.
REQ-033 Corner (3,2) in DRAIN -> center 023, left 022, right 023, up 013, down 023, UL 012, UR 013, DL 022, DR 023; eof_out=1.
REQ-034 Pixel (3,1) accepted -> in_ready=0 next cycle, window (3,0) with right=up-right=003-replicated field values (right 003, UR 003, DR 013).
REQ-035 sof with pixel 0xABC mid-RUN at (2,1) -> no window for (1,0); next frame windows start at (0,0) with center 0xABC.
REQ-036 pix_valid toggled 1/0 every cycle -> identical 12 windows, in_ready/window_valid never overlap illegal states.
REQ-037 Reset low during DRAIN -> window_valid=0 immediately, IDLE; non-sof pixel next -> no window, dropped.

Source files
------------

// File: rtl/window3x3_gen_pkg.sv
// -----------------------------------------------------------------------------
// window3x3_gen_pkg
// Shared definitions for the 3x3 window generator: pixel width, field offsets
// inside the 108-bit color_data word, FSM state encoding, the column record
// used by the shift registers and a helper that packs a window from columns.
// -----------------------------------------------------------------------------
package window3x3_gen_pkg;

    localparam int PIX_W = 12;
    localparam int WIN_W = 9 * PIX_W;

    localparam int OFF_CENTER = 96;
    localparam int OFF_LEFT   = 84;
    localparam int OFF_RIGHT  = 72;
    localparam int OFF_UP     = 60;
    localparam int OFF_DOWN   = 48;
    localparam int OFF_UL     = 36;
    localparam int OFF_UR     = 24;
    localparam int OFF_DL     = 12;
    localparam int OFF_DR     = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_EOL   = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    // One image column of the window: rows above, at and below the center.
    typedef struct packed {
        logic [PIX_W-1:0] top;
        logic [PIX_W-1:0] mid;
        logic [PIX_W-1:0] bot;
    } col_t;

    function automatic logic [WIN_W-1:0] pack_window(input col_t l, input col_t c, input col_t r);
        logic [WIN_W-1:0] w;
        w = '0;
        w[OFF_CENTER +: PIX_W] = c.mid;
        w[OFF_LEFT   +: PIX_W] = l.mid;
        w[OFF_RIGHT  +: PIX_W] = r.mid;
        w[OFF_UP     +: PIX_W] = c.top;
        w[OFF_DOWN   +: PIX_W] = c.bot;
        w[OFF_UL     +: PIX_W] = l.top;
        w[OFF_UR     +: PIX_W] = r.top;
        w[OFF_DL     +: PIX_W] = l.bot;
        w[OFF_DR     +: PIX_W] = r.bot;
        return w;
    endfunction

endpackage

// File: rtl/window3x3_gen_line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
// One image line of pixels. Asynchronous read and synchronous write at the
// same address, so a cycle that writes sees the previous contents
// (read-before-write). Storage is deliberately not reset.
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_addr   read/write address (pixel x)
//   i_wdata  pixel to store
//   o_rdata  pixel currently stored at i_addr
// -----------------------------------------------------------------------------
module line_buffer
    import window3x3_gen_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = 10
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [PIX_W-1:0] i_wdata,
    output logic [PIX_W-1:0] o_rdata
);

    logic [PIX_W-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

endmodule

// File: rtl/window3x3_gen.sv
// -----------------------------------------------------------------------------
// window3x3_gen
// Streams raster RGB444 pixels and emits, for every pixel of the frame, the
// 3x3 neighbourhood around it with edge replication. Two line buffers hold
// rows y-1 and y-2; a two-deep column shift register plus the incoming column
// form the window. Windows trail the input by one row and one column; the
// last row is flushed from the line buffers in DRAIN.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   pix_in/pix_valid  input pixel and its qualifier
//   sof               marks pix_in as pixel (0,0)
//   in_ready          pixel accepted when pix_valid && in_ready
//   color_data        packed window (center,left,right,up,down,UL,UR,DL,DR)
//   window_valid      one-cycle pulse per window
//   win_x, win_y      window center coordinates
//   eof_out           set with the last window of the frame
// -----------------------------------------------------------------------------
module window3x3_gen
    import window3x3_gen_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             sof,
    output logic             in_ready,
    output logic [WIN_W-1:0] color_data,
    output logic             window_valid,
    output logic [9:0]       win_x,
    output logic [9:0]       win_y,
    output logic             eof_out
);

    localparam int            AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [9:0]    XMAX  = 10'(IMG_W - 1);
    localparam logic [9:0]    YMAX  = 10'(IMG_H - 1);
    localparam logic [AW-1:0] AXMAX = AW'(IMG_W - 1);

    // Reset asserts asynchronously, releases two clocks later.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    state_e           r_state;
    logic             r_in_ready;
    logic [9:0]       r_x;       // x of the next pixel expected
    logic [9:0]       r_y;       // row currently being received
    logic [9:0]       r_dx;      // drain column
    col_t             r_c1;      // column x-1 (center in RUN)
    col_t             r_c2;      // column x-2
    col_t             w_new;
    col_t             w_left;
    col_t             w_right;
    logic [PIX_W-1:0] w_lb1_rd;
    logic [PIX_W-1:0] w_lb2_rd;
    logic [AW-1:0]    w_rd_addr;
    logic             w_acc;
    logic             w_sof_acc;
    logic             w_lb_we;
    logic             w_last_eol;
    logic             w_drain_col;
    logic             w_shift;
    logic             w_emit;
    logic             w_eof;
    logic [9:0]       w_wx;
    logic [9:0]       w_wy;

    logic [WIN_W-1:0] r_color;
    logic             r_wv;
    logic [9:0]       r_wx;
    logic [9:0]       r_wy;
    logic             r_eof;

    assign w_acc       = pix_valid && r_in_ready;
    assign w_sof_acc   = w_acc && sof;
    assign w_lb_we     = w_acc && ((r_state != ST_IDLE) || sof);
    assign w_last_eol  = (r_state == ST_EOL) && (r_y == YMAX);
    // In DRAIN (and the EOL that precedes it) columns come only from the line
    // buffers; the row below the last one is replicated from the last row.
    assign w_drain_col = (r_state == ST_DRAIN) || w_last_eol;
    assign w_shift     = w_lb_we || w_drain_col;

    always_comb begin
        w_rd_addr = r_x[AW-1:0];
        if (w_sof_acc)
            w_rd_addr = '0;
        else if (r_state == ST_DRAIN)
            w_rd_addr = (r_dx == XMAX) ? AXMAX : r_dx[AW-1:0] + AW'(1);
        else if (r_state == ST_EOL)
            w_rd_addr = '0;   // preload column 0 for DRAIN
    end

    line_buffer #(.DEPTH(IMG_W), .AW(AW)) u_lb_y1 (
        .i_clk   (clk),
        .i_we    (w_lb_we),
        .i_addr  (w_rd_addr),
        .i_wdata (pix_in),
        .o_rdata (w_lb1_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .AW(AW)) u_lb_y2 (
        .i_clk   (clk),
        .i_we    (w_lb_we),
        .i_addr  (w_rd_addr),
        .i_wdata (w_lb1_rd),
        .o_rdata (w_lb2_rd)
    );

    // Incoming column. While receiving row 1 the row above the center is row 0
    // itself, so the top is replicated from the middle.
    always_comb begin
        w_new.mid = w_lb1_rd;
        w_new.top = ((r_state == ST_RUN) && (r_y == 10'd1)) ? w_lb1_rd : w_lb2_rd;
        w_new.bot = w_drain_col ? w_lb1_rd : pix_in;
    end

    always_ff @(posedge clk) begin
        if (w_shift) begin
            r_c2 <= r_c1;
            r_c1 <= w_new;
        end
    end

    // Window selection; the left/right replication happens at x=0 / x=W-1.
    always_comb begin
        w_emit  = 1'b0;
        w_left  = r_c2;
        w_right = w_new;
        w_wx    = r_x - 10'd1;
        w_wy    = r_y - 10'd1;
        w_eof   = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_emit = w_acc && !sof && (r_x != 10'd0);
                if (r_x == 10'd1) w_left = r_c1;
            end
            ST_EOL: begin
                w_emit  = 1'b1;
                w_right = r_c1;
                w_wx    = XMAX;
            end
            ST_DRAIN: begin
                w_emit = 1'b1;
                if (r_dx == 10'd0) w_left = r_c1;
                w_wx   = r_dx;
                w_wy   = YMAX;
                w_eof  = (r_dx == XMAX);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
            r_x        <= '0;
            r_y        <= '0;
            r_dx       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sof_acc) begin
                        r_state <= ST_FILL;
                        r_x     <= 10'd1;
                        r_y     <= '0;
                    end
                end
                ST_FILL, ST_RUN: begin
                    if (w_sof_acc) begin
                        // Abort: this pixel restarts the frame at (0,0).
                        r_state <= ST_FILL;
                        r_x     <= 10'd1;
                        r_y     <= '0;
                    end else if (w_acc) begin
                        if (r_x == XMAX) begin
                            r_x <= '0;
                            if (r_y == 10'd0) begin
                                r_y     <= 10'd1;
                                r_state <= ST_RUN;
                            end else begin
                                r_state    <= ST_EOL;
                                r_in_ready <= 1'b0;
                            end
                        end else begin
                            r_x <= r_x + 10'd1;
                        end
                    end
                end
                ST_EOL: begin
                    if (r_y == YMAX) begin
                        r_state <= ST_DRAIN;
                        r_dx    <= '0;
                    end else begin
                        r_y        <= r_y + 10'd1;
                        r_state    <= ST_RUN;
                        r_in_ready <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_dx == XMAX) begin
                        r_state    <= ST_IDLE;
                        r_in_ready <= 1'b1;
                        r_y        <= '0;
                        r_dx       <= '0;
                    end else begin
                        r_dx <= r_dx + 10'd1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_color <= '0;
            r_wv    <= 1'b0;
            r_wx    <= '0;
            r_wy    <= '0;
            r_eof   <= 1'b0;
        end else begin
            r_wv <= w_emit;
            if (w_emit) begin
                r_color <= pack_window(w_left, r_c1, w_right);
                r_wx    <= w_wx;
                r_wy    <= w_wy;
                r_eof   <= w_eof;
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign color_data   = r_color;
    assign window_valid = r_wv;
    assign win_x        = r_wx;
    assign win_y        = r_wy;
    assign eof_out      = r_eof;

endmodule

// File: tb/tb_window3x3_gen.sv
module tb_window3x3_gen;
    import window3x3_gen_pkg::*;

    localparam int W = 4;
    localparam int H = 3;

    localparam logic [107:0] FIRST_WIN  = 108'h000_000_001_000_010_000_001_010_011;
    localparam logic [107:0] CORNER_WIN = 108'h023_022_023_013_023_012_013_022_023;
    localparam logic [107:0] EOL_WIN    = 108'h003_002_003_003_013_002_003_012_013;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [11:0]  pix_in = '0;
    logic         pix_valid = 1'b0;
    logic         sof = 1'b0;
    logic         in_ready;
    logic [107:0] color_data;
    logic         window_valid;
    logic [9:0]   win_x;
    logic [9:0]   win_y;
    logic         eof_out;

    window3x3_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk          (clk),
        .reset        (reset),
        .pix_in       (pix_in),
        .pix_valid    (pix_valid),
        .sof          (sof),
        .in_ready     (in_ready),
        .color_data   (color_data),
        .window_valid (window_valid),
        .win_x        (win_x),
        .win_y        (win_y),
        .eof_out      (eof_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [107:0] d;
        logic [9:0]   x;
        logic [9:0]   y;
        logic         eof;
    } win_t;

    win_t        exp_q[$];
    win_t        obs_q[$];
    logic [11:0] img [W][H];
    int          n_vec = 0;
    int          n_err = 0;
    int          wv_cnt = 0;
    bit          cap_en = 1'b1;

    always @(negedge clk) begin
        if (window_valid === 1'b1) begin
            wv_cnt++;
            if (cap_en) obs_q.push_back('{d: color_data, x: win_x, y: win_y, eof: eof_out});
        end
    end

    // Reference: clamp coordinates into the image and read the stored frame.
    function automatic logic [11:0] px(input int x, input int y);
        int cx = (x < 0) ? 0 : ((x > W - 1) ? W - 1 : x);
        int cy = (y < 0) ? 0 : ((y > H - 1) ? H - 1 : y);
        return img[cx][cy];
    endfunction

    function automatic win_t model_win(input int x, input int y);
        win_t w;
        w.d   = {px(x, y), px(x - 1, y), px(x + 1, y), px(x, y - 1), px(x, y + 1),
                 px(x - 1, y - 1), px(x + 1, y - 1), px(x - 1, y + 1), px(x + 1, y + 1)};
        w.x   = 10'(x);
        w.y   = 10'(y);
        w.eof = (x == W - 1) && (y == H - 1);
        return w;
    endfunction

    task automatic default_img();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[x][y] = {4'h0, 4'(y), 4'(x)};
    endtask

    task automatic push_frame();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                exp_q.push_back(model_win(x, y));
    endtask

    // Holds the pixel on the bus until a clock edge with in_ready high.
    task automatic send_pixel(input logic s, input logic [11:0] p);
        bit acc = 1'b0;
        pix_valid = 1'b1;
        sof = s;
        pix_in = p;
        for (int k = 0; k < 40 && !acc; k++) begin
            acc = (in_ready === 1'b1);
            @(negedge clk);
        end
        pix_valid = 1'b0;
        sof = 1'b0;
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL send_pixel timeout: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic send_frame(input bit gap);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                send_pixel(x == 0 && y == 0, img[x][y]);
                if (gap) @(negedge clk);
            end
    endtask

    task automatic wait_done();
        for (int k = 0; k < 60 && obs_q.size() < exp_q.size(); k++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_vec += 6;
        if (in_ready !== 1'b1)     begin n_err++; $display("FAIL reset in_ready: got %b, want 1", in_ready); end
        if (window_valid !== 1'b0) begin n_err++; $display("FAIL reset window_valid: got %b, want 0", window_valid); end
        if (color_data !== '0)     begin n_err++; $display("FAIL reset color_data: got %h, want 0", color_data); end
        if (win_x !== '0)          begin n_err++; $display("FAIL reset win_x: got %0d, want 0", win_x); end
        if (win_y !== '0)          begin n_err++; $display("FAIL reset win_y: got %0d, want 0", win_y); end
        if (eof_out !== 1'b0)      begin n_err++; $display("FAIL reset eof_out: got %b, want 0", eof_out); end
        reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_full_frame();
        win_t e, o;
        default_img();
        push_frame();
        send_frame(1'b0);
        wait_done();
        n_vec += 2;
        if (obs_q.size() == 0 || obs_q[0].d !== FIRST_WIN) begin
            n_err++; $display("FAIL full first window: got %h, want %h", (obs_q.size() != 0) ? obs_q[0].d : '0, FIRST_WIN);
        end
        if (obs_q.size() == 0 || obs_q[$].d !== CORNER_WIN || obs_q[$].eof !== 1'b1) begin
            n_err++; $display("FAIL full corner window: got %h, want %h with eof", (obs_q.size() != 0) ? obs_q[$].d : '0, CORNER_WIN);
        end
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL full count: got %0d windows, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++; $display("FAIL full win: got x=%0d y=%0d eof=%b d=%h, want x=%0d y=%0d eof=%b d=%h", o.x, o.y, o.eof, o.d, e.x, e.y, e.eof, e.d);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_eol_stall();
        win_t e, o;
        default_img();
        push_frame();
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < W; x++) send_pixel(x == 0 && y == 0, img[x][y]);
        // Just after (3,1) was taken: stalled, window (2,0) on the outputs.
        n_vec += 2;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL eol in_ready: got %b, want 0", in_ready); end
        if (window_valid !== 1'b1 || win_x !== 10'd2 || win_y !== 10'd0) begin
            n_err++; $display("FAIL eol prev window: got v=%b x=%0d y=%0d, want v=1 x=2 y=0", window_valid, win_x, win_y);
        end
        @(negedge clk);
        n_vec += 2;
        if (window_valid !== 1'b1 || win_x !== 10'd3 || win_y !== 10'd0) begin
            n_err++; $display("FAIL eol window pos: got v=%b x=%0d y=%0d, want v=1 x=3 y=0", window_valid, win_x, win_y);
        end
        if (color_data !== EOL_WIN) begin n_err++; $display("FAIL eol window data: got %h, want %h", color_data, EOL_WIN); end
        for (int x = 0; x < W; x++) send_pixel(1'b0, img[x][2]);
        wait_done();
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL eol count: got %0d windows, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++; $display("FAIL eol win: got x=%0d y=%0d eof=%b d=%h, want x=%0d y=%0d eof=%b d=%h", o.x, o.y, o.eof, o.d, e.x, e.y, e.eof, e.d);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_abort();
        win_t e, o;
        default_img();
        // Old frame up to (1,1); only window (0,0) can come out of it.
        exp_q.push_back(model_win(0, 0));
        for (int i = 0; i < W + 2; i++) send_pixel(i == 0, img[i % W][i / W]);
        img[0][0] = 12'hABC;
        push_frame();
        send_pixel(1'b1, 12'hABC);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (x != 0 || y != 0) send_pixel(1'b0, img[x][y]);
        wait_done();
        n_vec++;
        if (obs_q.size() < 2 || obs_q[1].x !== 10'd0 || obs_q[1].y !== 10'd0 || obs_q[1].d[107:96] !== 12'hABC) begin
            n_err++; $display("FAIL abort restart: got %0d windows, second center=%h, want (0,0) center abc",
                              obs_q.size(), (obs_q.size() > 1) ? obs_q[1].d[107:96] : 12'h0);
        end
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL abort count: got %0d windows, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++; $display("FAIL abort win: got x=%0d y=%0d eof=%b d=%h, want x=%0d y=%0d eof=%b d=%h", o.x, o.y, o.eof, o.d, e.x, e.y, e.eof, e.d);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_gaps();
        win_t e, o;
        default_img();
        push_frame();
        send_frame(1'b1);
        wait_done();
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL gaps count: got %0d windows, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++; $display("FAIL gaps win: got x=%0d y=%0d eof=%b d=%h, want x=%0d y=%0d eof=%b d=%h", o.x, o.y, o.eof, o.d, e.x, e.y, e.eof, e.d);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_drain();
        win_t e, o;
        int cnt0;
        cap_en = 1'b0;
        default_img();
        send_frame(1'b0);
        repeat (2) @(negedge clk);   // now in DRAIN with a window on the outputs
        #2 reset = 1'b0;
        #1;
        n_vec += 2;
        if (window_valid !== 1'b0) begin n_err++; $display("FAIL drain reset window_valid: got %b, want 0", window_valid); end
        if (in_ready !== 1'b1)     begin n_err++; $display("FAIL drain reset in_ready: got %b, want 1", in_ready); end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        cnt0 = wv_cnt;
        send_pixel(1'b0, 12'h123);
        repeat (4) @(negedge clk);
        n_vec += 2;
        if (wv_cnt != cnt0) begin n_err++; $display("FAIL drain non-sof dropped: got %0d windows, want 0", wv_cnt - cnt0); end
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL drain idle in_ready: got %b, want 1", in_ready); end
        // A clean frame after the reset must come out whole.
        obs_q.delete();
        cap_en = 1'b1;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) img[x][y] = 12'($urandom_range(0, 4095));
        push_frame();
        send_frame(1'b0);
        wait_done();
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL recover count: got %0d windows, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++; $display("FAIL recover win: got x=%0d y=%0d eof=%b d=%h, want x=%0d y=%0d eof=%b d=%h", o.x, o.y, o.eof, o.d, e.x, e.y, e.eof, e.d);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        #2;
        test_reset();
        test_full_frame();
        test_eol_stall();
        test_abort();
        test_gaps();
        test_reset_drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
